// File: rtl/match_controller.sv
// Pong match sequencer: serve countdown, scoring from miss events, win detection,
// start/pause button handling. Drives the game-logic restart/pause controls.
module match_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned SERVE_DELAY = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               game_rst,
  output logic               game_pause,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   DELAY_VAL = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  state_t             cur_state;
  logic [CNT_W-1:0]   serve_cnt;
  logic               start_prev;
  logic               pause_prev;
  logic               start_edge;
  logic               pause_edge;
  logic [SCORE_W-1:0] left_inc;
  logic [SCORE_W-1:0] right_inc;

  assign start_edge = btn_start & ~start_prev;
  assign pause_edge = btn_pause & ~pause_prev;
  assign left_inc   = score_left + SCORE_ONE;
  assign right_inc  = score_right + SCORE_ONE;
  assign state      = cur_state;

  // game_rst/game_pause are registered alongside every transition so they
  // always reflect the state being entered on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state   <= IDLE;
      serve_cnt   <= '0;
      score_left  <= '0;
      score_right <= '0;
      winner      <= '0;
      game_rst    <= 1'b1;
      game_pause  <= 1'b1;
      start_prev  <= 1'b1;
      pause_prev  <= 1'b1;
    end else begin
      start_prev <= btn_start;
      pause_prev <= btn_pause;
      case (cur_state)
        IDLE, OVER: begin
          game_rst   <= 1'b1;
          game_pause <= 1'b1;
          if (start_edge) begin
            score_left  <= '0;
            score_right <= '0;
            winner      <= '0;
            serve_cnt   <= DELAY_VAL;
            cur_state   <= SERVE;
          end
        end

        SERVE: begin
          game_rst   <= 1'b1;
          game_pause <= 1'b1;
          if (tick) begin
            serve_cnt <= serve_cnt - CNT_ONE;
            if (serve_cnt == CNT_ONE) begin
              cur_state  <= PLAY;
              game_rst   <= 1'b0;
              game_pause <= 1'b0;
            end
          end
        end

        PLAY: begin
          game_rst   <= 1'b0;
          game_pause <= 1'b0;
          if (miss_left && miss_right) begin
            serve_cnt  <= DELAY_VAL;
            cur_state  <= SERVE;
            game_rst   <= 1'b1;
            game_pause <= 1'b1;
          end else if (miss_left) begin
            score_right <= right_inc;
            game_rst    <= 1'b1;
            game_pause  <= 1'b1;
            if (right_inc == WIN_VAL) begin
              winner    <= 2'b10;
              cur_state <= OVER;
            end else begin
              serve_cnt <= DELAY_VAL;
              cur_state <= SERVE;
            end
          end else if (miss_right) begin
            score_left <= left_inc;
            game_rst   <= 1'b1;
            game_pause <= 1'b1;
            if (left_inc == WIN_VAL) begin
              winner    <= 2'b01;
              cur_state <= OVER;
            end else begin
              serve_cnt <= DELAY_VAL;
              cur_state <= SERVE;
            end
          end else if (pause_edge) begin
            cur_state  <= PAUSED;
            game_pause <= 1'b1;
          end
        end

        PAUSED: begin
          game_rst   <= 1'b0;
          game_pause <= 1'b1;
          if (pause_edge) begin
            cur_state  <= PLAY;
            game_pause <= 1'b0;
          end
        end

        default: begin
          cur_state  <= IDLE;
          game_rst   <= 1'b1;
          game_pause <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenario with literal checks, then
// randomized play compared every cycle against a behavioural match model.
module tb_match_controller;

  localparam int unsigned WS = 3;
  localparam int unsigned SW = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tick = 1'b0;
  logic          btn_start = 1'b0;
  logic          btn_pause = 1'b0;
  logic          miss_left = 1'b0;
  logic          miss_right = 1'b0;
  logic          game_rst;
  logic          game_pause;
  logic [SW-1:0] score_left;
  logic [SW-1:0] score_right;
  logic [1:0]    winner;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: phase numbers are the externally visible state codes.
  int m_phase, m_sl, m_sr, m_win, m_ticks_left;
  bit m_start_last, m_pause_last;

  match_controller #(
    .WIN_SCORE(WS),
    .SCORE_W(SW),
    .SERVE_DELAY(SD),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .tick(tick),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .miss_left(miss_left),
    .miss_right(miss_right),
    .game_rst(game_rst),
    .game_pause(game_pause),
    .score_left(score_left),
    .score_right(score_right),
    .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; m_ticks_left = 0;
    m_start_last = 1'b1; m_pause_last = 1'b1;
  endfunction

  function automatic void new_match();
    m_sl = 0; m_sr = 0; m_win = 0; m_ticks_left = SD; m_phase = 1;
  endfunction

  function automatic void model_step();
    bit started, paused;
    if (!rst_n) begin
      model_reset();
      return;
    end
    started = btn_start && !m_start_last;
    paused  = btn_pause && !m_pause_last;
    if (m_phase == 0 || m_phase == 4) begin
      if (started) new_match();
    end else if (m_phase == 1) begin
      if (tick) begin
        m_ticks_left = m_ticks_left - 1;
        if (m_ticks_left == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (miss_left || miss_right) begin
        if (miss_left && !miss_right) m_sr = m_sr + 1;
        if (miss_right && !miss_left) m_sl = m_sl + 1;
        if (m_sr == WS) m_win = 2;
        if (m_sl == WS) m_win = 1;
        if (m_win != 0) m_phase = 4;
        else begin m_phase = 1; m_ticks_left = SD; end
      end else if (paused) m_phase = 3;
    end else if (m_phase == 3) begin
      if (paused) m_phase = 2;
    end
    m_start_last = btn_start;
    m_pause_last = btn_pause;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_grst, exp_gpause;
      exp_grst   = !(m_phase == 2 || m_phase == 3);
      exp_gpause = (m_phase != 2);
      checks++;
      if (state !== 3'(m_phase) || game_rst !== exp_grst || game_pause !== exp_gpause ||
          score_left !== SW'(m_sl) || score_right !== SW'(m_sr) || winner !== 2'(m_win)) begin
        errors++;
        $display("FAIL cycle_model t=%0t actual st=%0d grst=%0b gp=%0b sl=%0d sr=%0d win=%0d required st=%0d grst=%0b gp=%0b sl=%0d sr=%0d win=%0d",
                 $time, state, game_rst, game_pause, score_left, score_right, winner,
                 m_phase, exp_grst, exp_gpause, m_sl, m_sr, m_win);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) model_reset();
  endtask

  // Drive one cycle of inputs, let the edge sample them, return at edge+1.
  task automatic cyc(input bit t, input bit bs, input bit bp, input bit ml, input bit mr);
    tick = t; btn_start = bs; btn_pause = bp; miss_left = ml; miss_right = mr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_serve();
    for (int i = 0; i < int'(SD); i++) cyc(1, 0, 0, 0, 0);
  endtask

  initial begin
    int rst_hold;
    bit bs, bp;
    model_reset();
    btn_start = 1'b1;
    #2;
    set_rst(1'b0);
    #1;
    cmp_en = 1'b1;
    check_lit("reset_state", state, 0);
    check_lit("reset_game_rst", game_rst, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    set_rst(1'b1);

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    check_lit("held_start_no_edge", state, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check_lit("start_state", state, 1);
    check_lit("start_game_rst", game_rst, 1);
    check_lit("start_scores", {score_left, score_right}, 0);

    for (int k = 1; k <= int'(SD); k++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      if (k == int'(SD)) check_lit("serve_before_last_tick", state, 1);
      cyc(1, 0, 0, 0, 0);
    end
    check_lit("serve_done_state", state, 2);
    check_lit("serve_done_game_rst", game_rst, 0);
    check_lit("serve_done_game_pause", game_pause, 0);

    cyc(0, 0, 0, 1, 0);
    check_lit("miss_left_score_right", score_right, 1);
    check_lit("miss_left_state", state, 1);
    do_serve();
    cyc(0, 0, 0, 0, 1);
    check_lit("miss_right_score_left", score_left, 1);
    do_serve();

    cyc(0, 0, 1, 0, 0);
    check_lit("pause_state", state, 3);
    check_lit("pause_game_pause", game_pause, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_lit("paused_miss_ignored", score_right, 1);
    cyc(0, 0, 1, 0, 0);
    check_lit("unpause_state", state, 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check_lit("double_miss_state", state, 1);
    check_lit("double_miss_scores", {score_left, score_right}, 8'h11);
    do_serve();
    cyc(0, 0, 1, 1, 0);
    check_lit("miss_beats_pause_score", score_right, 2);
    check_lit("miss_beats_pause_state", state, 1);
    do_serve();

    cyc(0, 0, 0, 1, 0);
    check_lit("win_score_right", score_right, 3);
    check_lit("win_winner", winner, 2);
    check_lit("win_state", state, 4);
    cyc(0, 0, 0, 1, 0);
    check_lit("over_miss_ignored", score_right, 3);
    cyc(0, 1, 0, 0, 0);
    check_lit("restart_state", state, 1);
    check_lit("restart_clear", {winner, score_left, score_right}, 0);
    cyc(0, 0, 0, 0, 0);

    do_serve();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    set_rst(1'b0);
    #1;
    check_lit("midreset_state", state, 0);
    check_lit("midreset_score_left", score_left, 0);
    check_lit("midreset_outputs", {game_rst, game_pause, winner}, 4'b1100);
    cyc(0, 0, 0, 0, 0);
    set_rst(1'b1);
    cyc(0, 0, 0, 0, 0);
    check_lit("post_reset_state", state, 0);

    bs = 1'b0; bp = 1'b0; rst_hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) set_rst(1'b1);
      end else if ($urandom_range(399) == 0) begin
        set_rst(1'b0);
        rst_hold = 1 + $urandom_range(2);
      end
      if ($urandom_range(3) == 0) bs = ~bs;
      if ($urandom_range(5) == 0) bp = ~bp;
      cyc($urandom_range(2) == 0, bs, bp, $urandom_range(5) == 0, $urandom_range(5) == 0);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
